// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared state encoding, default timing and helpers for the lock controller
//
// Contents:
//   ST_*          FSM state encoding (3-bit)
//   DEF_*         default timing / sizing values for lock_ctrl parameters
//   err_bump()    saturating increment of the wrong-attempt counter

package lock_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CHECK   = 3'd1;
    localparam logic [2:0] ST_OPEN    = 3'd2;
    localparam logic [2:0] ST_FAIL    = 3'd3;
    localparam logic [2:0] ST_LOCKOUT = 3'd4;

    localparam int DEF_MAX_TRIES      = 3;
    localparam int DEF_UNLOCK_CYCLES  = 50_000_000;
    localparam int DEF_FAIL_CYCLES    = 25_000_000;
    localparam int DEF_LOCKOUT_CYCLES = 250_000_000;
    localparam int DEF_TW             = 28;

    // Counter stops at the limit instead of wrapping back to zero.
    function automatic logic [1:0] err_bump(input logic [1:0] cnt, input logic [1:0] limit);
        return (cnt == limit) ? cnt : cnt + 2'd1;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// rtl/lock_timer.sv - loadable down-counter that holds at zero
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset, clears the count
//   load   load value into the counter this cycle
//   value  count to load (state duration minus one)
//   done   count currently reads zero

module lock_timer #(
    parameter int TW = 28
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] value,
    output logic          done
);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/lock_ctrl.sv
// rtl/lock_ctrl.sv - code lock controller with retry lockout and password change
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   sw[7:0]     entered code / new password
//   enter_trig  pulse: submit sw as an attempt (accepted in IDLE only)
//   set_trig    pulse: store sw as new password (accepted in OPEN only)
//   unlock      door open indication
//   fail        wrong-code indication
//   alarm       lockout indication
//   err_cnt     consecutive wrong attempts
//   busy        controller not in IDLE
//   pwd_set     one-cycle pulse when the password was updated

module lock_ctrl
    import lock_pkg::*;
#(
    parameter logic [7:0] DEFAULT_PWD    = 8'h00,
    parameter int         MAX_TRIES      = DEF_MAX_TRIES,
    parameter int         UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
    parameter int         FAIL_CYCLES    = DEF_FAIL_CYCLES,
    parameter int         LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int         TW             = DEF_TW
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    input  logic       enter_trig,
    input  logic       set_trig,
    output logic       unlock,
    output logic       fail,
    output logic       alarm,
    output logic [1:0] err_cnt,
    output logic       busy,
    output logic       pwd_set
);

    localparam logic [1:0]    MAX_ERR    = 2'(MAX_TRIES);
    localparam logic [TW-1:0] UNLOCK_LD  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] FAIL_LD    = TW'(FAIL_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LD = TW'(LOCKOUT_CYCLES - 1);

    logic [2:0]    state;
    logic [2:0]    next_state;
    logic [7:0]    pwd;
    logic [7:0]    attempt;
    logic [1:0]    err_nxt;
    logic [1:0]    err_inc;
    logic          pwd_wr;
    logic          t_load;
    logic [TW-1:0] t_value;
    logic          t_done;

    lock_timer #(
        .TW(TW)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (t_load),
        .value (t_value),
        .done  (t_done)
    );

    assign err_inc = err_bump(err_cnt, MAX_ERR);

    always_comb begin
        next_state = state;
        err_nxt    = err_cnt;
        pwd_wr     = 1'b0;
        t_load     = 1'b0;
        t_value    = '0;
        case (state)
            ST_IDLE: begin
                // enter_trig wins over set_trig here simply because set_trig is ignored in IDLE
                if (enter_trig) begin
                    next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                t_load = 1'b1;
                if (attempt == pwd) begin
                    err_nxt    = 2'd0;
                    next_state = ST_OPEN;
                    t_value    = UNLOCK_LD;
                end else begin
                    err_nxt = err_inc;
                    if (err_inc == MAX_ERR) begin
                        next_state = ST_LOCKOUT;
                        t_value    = LOCKOUT_LD;
                    end else begin
                        next_state = ST_FAIL;
                        t_value    = FAIL_LD;
                    end
                end
            end
            ST_OPEN: begin
                if (set_trig) begin
                    // Early exit: zero the timer so it does not keep running in IDLE
                    pwd_wr     = 1'b1;
                    next_state = ST_IDLE;
                    t_load     = 1'b1;
                end else if (t_done) begin
                    next_state = ST_IDLE;
                end
            end
            ST_FAIL: begin
                if (t_done) begin
                    next_state = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (t_done) begin
                    next_state = ST_IDLE;
                    err_nxt    = 2'd0;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered copies of the decoded next state, so they
    // line up with the state register and are mutually exclusive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pwd     <= DEFAULT_PWD;
            attempt <= 8'h00;
            err_cnt <= 2'd0;
            unlock  <= 1'b0;
            fail    <= 1'b0;
            alarm   <= 1'b0;
            busy    <= 1'b0;
            pwd_set <= 1'b0;
        end else begin
            state   <= next_state;
            err_cnt <= err_nxt;
            unlock  <= (next_state == ST_OPEN);
            fail    <= (next_state == ST_FAIL);
            alarm   <= (next_state == ST_LOCKOUT);
            busy    <= (next_state != ST_IDLE);
            pwd_set <= pwd_wr;
            if (pwd_wr) begin
                pwd <= sw;
            end
            if (state == ST_IDLE && enter_trig) begin
                attempt <= sw;
            end
        end
    end

endmodule

// File: tb/tb_lock_ctrl.sv
// tb/tb_lock_ctrl.sv - scoreboard testbench for lock_ctrl

module tb_lock_ctrl;

    localparam int W = 22;

    typedef struct {
        string tag;
        int    lat;
        int    last;
        int    unl;
        int    fl;
        int    alm;
        int    busy;
        int    pset;
        int    err_at;
        int    err_end;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sw = 8'h00;
    logic       enter_trig = 1'b0;
    logic       set_trig = 1'b0;
    logic       unlock;
    logic       fail;
    logic       alarm;
    logic [1:0] err_cnt;
    logic       busy;
    logic       pwd_set;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    lock_ctrl #(
        .DEFAULT_PWD    (8'hA5),
        .MAX_TRIES      (3),
        .UNLOCK_CYCLES  (8),
        .FAIL_CYCLES    (4),
        .LOCKOUT_CYCLES (16),
        .TW             (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw         (sw),
        .enter_trig (enter_trig),
        .set_trig   (set_trig),
        .unlock     (unlock),
        .fail       (fail),
        .alarm      (alarm),
        .err_cnt    (err_cnt),
        .busy       (busy),
        .pwd_set    (pwd_set)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input int lat, input int last, input int unl,
                                input int fl, input int alm, input int bsy, input int pset,
                                input int err_at, input int err_end);
        exp_t e;
        e.tag = tag; e.lat = lat; e.last = last; e.unl = unl; e.fl = fl; e.alm = alm;
        e.busy = bsy; e.pset = pset; e.err_at = err_at; e.err_end = err_end;
        return e;
    endfunction

    // Called at a negedge: drives one stimulus cycle, optionally injects a
    // second pulse at window cycle inj_k, observes W cycles, then scores.
    task automatic run_op(input exp_t e, input logic en, input logic st, input logic [7:0] swv,
                          input int inj_k, input logic inj_en, input logic inj_st,
                          input logic [7:0] inj_sw);
        int lat = -1, last = -1, n_unl = 0, n_fl = 0, n_alm = 0, n_busy = 0;
        int n_pset = 0, n_ovl = 0, err_at = -1, err_end;
        exp_t x;
        sb_q.push_back(e);
        enter_trig = en;
        set_trig   = st;
        sw         = swv;
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            if (unlock || fail || alarm) begin
                if (lat < 0) begin
                    lat    = k;
                    err_at = int'(err_cnt);
                end
                last = k;
            end
            n_unl  += int'(unlock);
            n_fl   += int'(fail);
            n_alm  += int'(alarm);
            n_busy += int'(busy);
            n_pset += int'(pwd_set);
            if (int'(unlock) + int'(fail) + int'(alarm) > 1) n_ovl++;
            if (k == inj_k) begin
                enter_trig = inj_en;
                set_trig   = inj_st;
                sw         = inj_sw;
            end else begin
                enter_trig = 1'b0;
                set_trig   = 1'b0;
            end
        end
        err_end = int'(err_cnt);
        x = sb_q.pop_front();
        chk({x.tag, ".lat"},     lat,    x.lat);
        chk({x.tag, ".last"},    last,   x.last);
        chk({x.tag, ".unlock"},  n_unl,  x.unl);
        chk({x.tag, ".fail"},    n_fl,   x.fl);
        chk({x.tag, ".alarm"},   n_alm,  x.alm);
        chk({x.tag, ".busy"},    n_busy, x.busy);
        chk({x.tag, ".pwd_set"}, n_pset, x.pset);
        chk({x.tag, ".err_at"},  err_at, x.err_at);
        chk({x.tag, ".err_end"}, err_end, x.err_end);
        chk({x.tag, ".onehot"},  n_ovl,  0);
        chk({x.tag, ".idle"},    int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst.unlock",  int'(unlock),  0);
        chk("rst.fail",    int'(fail),    0);
        chk("rst.alarm",   int'(alarm),   0);
        chk("rst.err_cnt", int'(err_cnt), 0);
        chk("rst.busy",    int'(busy),    0);
        chk("rst.pwd_set", int'(pwd_set), 0);

        // Release reset and submit on the very first edge afterwards
        rst_n = 1'b1;
        run_op(mk("ok_first", 2, 9, 8, 0, 0, 9, 0, 0, 0), 1'b1, 1'b0, 8'hA5, 0, 1'b0, 1'b0, 8'h00);

        run_op(mk("wrong1", 2, 5, 0, 4, 0, 5, 0, 1, 1), 1'b1, 1'b0, 8'h3C, 3, 1'b1, 1'b0, 8'hA5);
        run_op(mk("wrong2", 2, 5, 0, 4, 0, 5, 0, 2, 2), 1'b1, 1'b0, 8'h3C, 0, 1'b0, 1'b0, 8'h00);
        run_op(mk("lockout", 2, 17, 0, 0, 16, 17, 0, 3, 0), 1'b1, 1'b0, 8'h3C, 5, 1'b1, 1'b0, 8'hA5);

        run_op(mk("wrong_a", 2, 5, 0, 4, 0, 5, 0, 1, 1), 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 8'h00);
        run_op(mk("ok_clear", 2, 9, 8, 0, 0, 9, 0, 0, 0), 1'b1, 1'b0, 8'hA5, 0, 1'b0, 1'b0, 8'h00);

        run_op(mk("both_idle", 2, 9, 8, 0, 0, 9, 0, 0, 0), 1'b1, 1'b1, 8'hA5, 0, 1'b0, 1'b0, 8'h00);
        run_op(mk("set_idle", -1, -1, 0, 0, 0, 0, 0, -1, 0), 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 8'h00);
        run_op(mk("ok_after_set", 2, 9, 8, 0, 0, 9, 0, 0, 0), 1'b1, 1'b0, 8'hA5, 0, 1'b0, 1'b0, 8'h00);

        run_op(mk("change", 2, 4, 3, 0, 0, 4, 1, 0, 0), 1'b1, 1'b0, 8'hA5, 4, 1'b1, 1'b1, 8'h5A);
        run_op(mk("old_pwd", 2, 5, 0, 4, 0, 5, 0, 1, 1), 1'b1, 1'b0, 8'hA5, 0, 1'b0, 1'b0, 8'h00);
        run_op(mk("new_pwd", 2, 9, 8, 0, 0, 9, 0, 0, 0), 1'b1, 1'b0, 8'h5A, 0, 1'b0, 1'b0, 8'h00);

        // Reset in the middle of OPEN with the changed password
        enter_trig = 1'b1;
        sw = 8'h5A;
        @(negedge clk);
        enter_trig = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst.pre_unlock", int'(unlock), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst.unlock",  int'(unlock),  0);
        chk("midrst.fail",    int'(fail),    0);
        chk("midrst.alarm",   int'(alarm),   0);
        chk("midrst.err_cnt", int'(err_cnt), 0);
        chk("midrst.busy",    int'(busy),    0);
        chk("midrst.pwd_set", int'(pwd_set), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(mk("revert", 2, 9, 8, 0, 0, 9, 0, 0, 0), 1'b1, 1'b0, 8'hA5, 0, 1'b0, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
